// File: rtl/test_sequencer.sv
// Bench-side run controller: pulses core_reset, watches fetches for halt/timeout/hang, drains, then reports.
// Optional PC-hang detection is enabled by defining TEST_SEQ_HANG_DETECT_EN.
module test_sequencer #(
  parameter int AWIDTH       = 32,
  parameter int DWIDTH       = 32,
  parameter int CNT_WIDTH    = 32,
  parameter int RESET_CYCLES = 4,
  parameter int MAX_CYCLES   = 100000,
  parameter int DRAIN_CYCLES = 5,
  parameter logic [DWIDTH-1:0] HALT_INSN = 32'h00000073,
  parameter int STALL_LIMIT  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 insn_valid,
  input  logic [AWIDTH-1:0]    pc,
  input  logic [DWIDTH-1:0]    insn,
  output logic                 core_reset,
  output logic                 running,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic                 hang,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [DW-1:0]        drain_q, drain_d;
  logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0] fetch_q, fetch_d;
  logic                 pass_q, pass_d;
  logic                 timeout_q, timeout_d;
  logic                 hang_q, hang_d;
  logic                 haltEvt;
  logic                 hangEvt;

  assign haltEvt = insn_valid && (insn == HALT_INSN);

`ifdef TEST_SEQ_HANG_DETECT_EN
  localparam int SW = $clog2(STALL_LIMIT + 1);

  logic [AWIDTH-1:0] lastPc_q, lastPc_d;
  logic [SW-1:0]     stallCnt_q, stallCnt_d;

  // A zero stall count means no valid PC has been recorded yet in this run.
  always_comb begin
    lastPc_d   = lastPc_q;
    stallCnt_d = stallCnt_q;
    if (state_q == RUN && insn_valid) begin
      if (stallCnt_q != '0 && pc == lastPc_q) begin
        stallCnt_d = stallCnt_q + SW'(1);
      end else begin
        stallCnt_d = SW'(1);
        lastPc_d   = pc;
      end
    end
  end

  assign hangEvt = (state_q == RUN) && insn_valid && (stallCnt_d == SW'(STALL_LIMIT));

  always_ff @(posedge clock) begin
    if (!reset) begin
      lastPc_q   <= '0;
      stallCnt_q <= '0;
    end else begin
      lastPc_q   <= lastPc_d;
      stallCnt_q <= stallCnt_d;
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
  assign hangEvt   = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= HOLD;
      hold_q    <= '0;
      drain_q   <= '0;
      cycle_q   <= '0;
      fetch_q   <= '0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      hang_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      drain_q   <= drain_d;
      cycle_q   <= cycle_d;
      fetch_q   <= fetch_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      hang_q    <= hang_d;
    end
  end

  // Exit priority out of RUN: halt, then hang, then the cycle limit.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    drain_d   = drain_q;
    cycle_d   = cycle_q;
    fetch_d   = fetch_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    hang_d    = hang_q;
    unique case (state_q)
      HOLD: begin
        hold_d = hold_q + HW'(1);
        if (hold_q == HW'(RESET_CYCLES - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (cycle_q != '1) begin
          cycle_d = cycle_q + CNT_WIDTH'(1);
        end
        if (insn_valid && fetch_q != '1) begin
          fetch_d = fetch_q + CNT_WIDTH'(1);
        end
        drain_d = '0;
        if (haltEvt) begin
          pass_d  = 1'b1;
          state_d = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
        end else if (hangEvt) begin
          hang_d  = 1'b1;
          state_d = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
        end else if (cycle_q == CNT_WIDTH'(MAX_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      DRAIN: begin
        drain_d = drain_q + DW'(1);
        if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = HOLD;
      end
    endcase
  end

  assign core_reset  = (state_q == HOLD);
  assign running     = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign hang        = hang_q;
  assign cycle_count = cycle_q;
  assign fetch_count = fetch_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Self-checking bench for test_sequencer: directed vector table plus randomized runs against a run-level model.
module tb_test_sequencer;

  localparam int AWIDTH       = 32;
  localparam int DWIDTH       = 32;
  localparam int CNT_WIDTH    = 32;
  localparam int RESET_CYCLES = 4;
  localparam int MAX_CYCLES   = 20;
  localparam int DRAIN_CYCLES = 5;
  localparam logic [31:0] HALT = 32'h00000073;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam int STALL_LIMIT  = 16;
  localparam int STIM_LEN     = 64;
`ifdef TEST_SEQ_HANG_DETECT_EN
  localparam bit HANG_EN = 1'b1;
`else
  localparam bit HANG_EN = 1'b0;
`endif

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 insn_valid;
  logic [AWIDTH-1:0]    pc;
  logic [DWIDTH-1:0]    insn;
  logic                 core_reset, running, done, pass, timeout, hang;
  logic [CNT_WIDTH-1:0] cycle_count, fetch_count;

  int checks = 0;
  int errors = 0;

  logic        stimValid [STIM_LEN];
  logic [31:0] stimPc    [STIM_LEN];
  logic [31:0] stimInsn  [STIM_LEN];

  typedef struct {
    bit pass;
    bit timeout;
    bit hang;
    int cycles;
    int fetches;
  } result_t;

  typedef struct {
    int      validMode;
    int      pcMode;
    int      haltAt;
    result_t exp;
  } vec_t;

  test_sequencer #(
    .AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .CNT_WIDTH(CNT_WIDTH),
    .RESET_CYCLES(RESET_CYCLES), .MAX_CYCLES(MAX_CYCLES),
    .DRAIN_CYCLES(DRAIN_CYCLES), .HALT_INSN(HALT), .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clock(clock), .reset(reset), .insn_valid(insn_valid), .pc(pc), .insn(insn),
    .core_reset(core_reset), .running(running), .done(done), .pass(pass),
    .timeout(timeout), .hang(hang), .cycle_count(cycle_count), .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int i);
    insn_valid = stimValid[i];
    pc         = stimPc[i];
    insn       = stimInsn[i];
  endtask

  // Walks the run cycle by cycle using the exit rules directly.
  function automatic result_t refModel();
    result_t r;
    int stall;
    logic [31:0] lastPc;
    r = '{pass: 1'b0, timeout: 1'b0, hang: 1'b0, cycles: 0, fetches: 0};
    stall = 0;
    lastPc = '0;
    for (int i = 0; i < MAX_CYCLES; i++) begin
      r.cycles++;
      if (stimValid[i]) r.fetches++;
      if (stimValid[i] && stimInsn[i] == HALT) begin
        r.pass = 1'b1;
        break;
      end
      if (HANG_EN && stimValid[i]) begin
        stall = (stall > 0 && stimPc[i] == lastPc) ? stall + 1 : 1;
        lastPc = stimPc[i];
        if (stall == STALL_LIMIT) begin
          r.hang = 1'b1;
          break;
        end
      end
      if (i == MAX_CYCLES - 1) r.timeout = 1'b1;
    end
    return r;
  endfunction

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_core_reset"}, 64'(core_reset), 64'd1);
    checkOutput({tag, "_running"}, 64'(running), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_flags"}, 64'({pass, timeout, hang}), 64'd0);
    checkOutput({tag, "_cycle_count"}, 64'(cycle_count), 64'd0);
    checkOutput({tag, "_fetch_count"}, 64'(fetch_count), 64'd0);
  endtask

  // Full reset/hold/run/drain/done pass; abortDrain>=0 re-asserts reset that many cycles into DRAIN.
  task automatic runScenario(input string tag, input result_t exp, input int abortDrain);
    int n;
    int d;
    reset = 1'b0;
    insn_valid = 1'b0;
    pc = '0;
    insn = NOP;
    step();
    step();
    checkResetState({tag, "_rst"});
    reset = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!running && n < 50);
    checkOutput({tag, "_hold_cycles"}, 64'(n), 64'(RESET_CYCLES));
    checkOutput({tag, "_run_core_reset"}, 64'(core_reset), 64'd0);
    checkOutput({tag, "_run_start_cycle"}, 64'(cycle_count), 64'd0);
    n = 0;
    while (running && n < STIM_LEN) begin
      applyStimulus(n);
      step();
      n++;
    end
    checkOutput({tag, "_run_cycles"}, 64'(n), 64'(exp.cycles));
    insn_valid = 1'b1;
    insn = HALT;
    d = 0;
    while (!done && d < 50) begin
      if (d == abortDrain) begin
        reset = 1'b0;
        step();
        checkResetState({tag, "_abort"});
        reset = 1'b1;
        return;
      end
      checkOutput({tag, "_drain_idle"}, 64'({running, core_reset}), 64'd0);
      step();
      d++;
    end
    checkOutput({tag, "_drain_cycles"}, 64'(d), 64'(exp.timeout ? 0 : DRAIN_CYCLES));
    checkOutput({tag, "_flags"}, 64'({pass, timeout, hang}), 64'({exp.pass, exp.timeout, exp.hang}));
    checkOutput({tag, "_cycle_count"}, 64'(cycle_count), 64'(exp.cycles));
    checkOutput({tag, "_fetch_count"}, 64'(fetch_count), 64'(exp.fetches));
    for (int k = 0; k < 3; k++) begin
      insn_valid = 1'($urandom_range(0, 1));
      insn = $urandom;
      pc = $urandom;
      step();
    end
    checkOutput({tag, "_done_hold"}, 64'({done, running, core_reset, pass, timeout, hang}),
                64'({1'b1, 1'b0, 1'b0, exp.pass, exp.timeout, exp.hang}));
    checkOutput({tag, "_done_counts"}, {32'(cycle_count), 32'(fetch_count)},
                {32'(exp.cycles), 32'(exp.fetches)});
  endtask

  task automatic buildVector(input vec_t v);
    for (int i = 0; i < STIM_LEN; i++) begin
      stimValid[i] = (v.validMode == 0) ? 1'b1 : (i % 2 == 0);
      stimPc[i]    = (v.pcMode == 0) ? 32'(i * 4) : 32'h100;
      stimInsn[i]  = (i == v.haltAt) ? HALT : NOP;
    end
  endtask

  initial begin
    vec_t    vecs[7];
    result_t exp;
    int      kind;
    logic [31:0] base;

    vecs[0] = '{validMode: 0, pcMode: 0, haltAt: 3,  exp: '{1'b1, 1'b0, 1'b0, 4, 4}};
    vecs[1] = '{validMode: 0, pcMode: 0, haltAt: -1, exp: '{1'b0, 1'b1, 1'b0, 20, 20}};
    vecs[2] = '{validMode: 0, pcMode: 1, haltAt: -1,
                exp: '{1'b0, !HANG_EN, HANG_EN, HANG_EN ? 16 : 20, HANG_EN ? 16 : 20}};
    vecs[3] = '{validMode: 0, pcMode: 0, haltAt: 19, exp: '{1'b1, 1'b0, 1'b0, 20, 20}};
    vecs[4] = '{validMode: 1, pcMode: 0, haltAt: 10, exp: '{1'b1, 1'b0, 1'b0, 11, 6}};
    vecs[5] = '{validMode: 1, pcMode: 1, haltAt: -1, exp: '{1'b0, 1'b1, 1'b0, 20, 10}};
    vecs[6] = '{validMode: 0, pcMode: 1, haltAt: 15, exp: '{1'b1, 1'b0, 1'b0, 16, 16}};

    reset = 1'b0;
    insn_valid = 1'b0;
    pc = '0;
    insn = NOP;

    foreach (vecs[v]) begin
      buildVector(vecs[v]);
      runScenario($sformatf("vec%0d", v), vecs[v].exp, -1);
    end

    // Abort two cycles into the drain of the halt run, then rerun it from scratch.
    buildVector(vecs[0]);
    runScenario("abort", vecs[0].exp, 2);
    runScenario("rerun", vecs[0].exp, -1);

    for (int r = 0; r < 20; r++) begin
      kind = $urandom_range(0, 2);
      base = 32'($urandom_range(0, 255) * 4);
      for (int i = 0; i < STIM_LEN; i++) begin
        stimValid[i] = (kind == 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) != 0);
        case (kind)
          0:       stimPc[i] = base + 32'(i * 4);
          1:       stimPc[i] = base;
          default: stimPc[i] = base + 32'($urandom_range(0, 1) * 4);
        endcase
        stimInsn[i] = ($urandom_range(0, 29) == 0) ? HALT : $urandom;
        if (stimInsn[i] == HALT && $urandom_range(0, 29) != 0) stimInsn[i] = NOP;
      end
      exp = refModel();
      runScenario($sformatf("rand%0d", r), exp, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
